// File: rtl/fp27_pkg.sv
// Shared definitions for the 27-bit GMM float format (1 sign, 8 exponent, 18 fraction)
// and the iterative divider built on it.
package fp27_pkg;

   localparam int W_EXP    = 8;
   localparam int W_FRAC   = 18;
   localparam int EXP_BIAS = 127;
   localparam int W_FP     = 1 + W_EXP + W_FRAC;
   localparam int W_MANT   = W_FRAC;
   localparam int W_REM    = W_MANT + 1;
   localparam int Q_BITS   = W_FRAC + 2;
   localparam int W_CNT    = $clog2(Q_BITS);
   localparam int W_ESGN   = W_EXP + 2;

   localparam int SIGN_BIT = W_FP - 1;
   localparam int EXP_HI   = W_FP - 2;
   localparam int EXP_LO   = W_FRAC;
   localparam int FRAC_HI  = W_FRAC - 1;

   localparam logic [W_FP-1:0] FP_ZERO    = 27'h0000000;
   localparam logic [W_FP-1:0] FP_MAX_POS = {1'b0, 8'hFE, 18'h3FFFF};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      NORM = 2'd2
   } div_state_e;

   // Hidden one plus the upper 17 fraction bits; the field LSB carries no weight.
   function automatic logic [W_MANT-1:0] fp_mant(input logic [W_FP-1:0] x);
      return {1'b1, x[FRAC_HI:1]};
   endfunction

endpackage

// File: rtl/fp27_div_step.sv
// One restoring-division step: compare, conditionally subtract, shift left.
module fp27_div_step
   import fp27_pkg::*;
(
   input  logic [W_REM-1:0]  rem,
   input  logic [W_MANT-1:0] divisor,
   output logic              qbit,
   output logic [W_REM-1:0]  rem_next
);

   logic [W_MANT-1:0] diff_s;

   // Partial remainder stays below the divisor, so it always fits W_MANT bits before the shift.
   always_comb begin
      qbit   = (rem >= {1'b0, divisor});
      diff_s = W_MANT'(rem - {1'b0, divisor});
      if (qbit) begin
         rem_next = {diff_s, 1'b0};
      end else begin
         rem_next = {rem[W_REM-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative 27-bit float divider: one quotient bit per clock, fixed 21-cycle latency
// from accept to result, start/valid handshake.
module fp_div_iter
   import fp27_pkg::*;
(
   input  logic            iClk,
   input  logic            iRst_n,
   input  logic            iStart,
   input  logic [W_FP-1:0] iA,
   input  logic [W_FP-1:0] iB,
   output logic            oBusy,
   output logic            oValid,
   output logic [W_FP-1:0] oQuot,
   output logic            oDivZero,
   output logic            oOvf
);

   div_state_e          state_q, state_d;
   logic [W_CNT-1:0]    cnt_q, cnt_d;
   logic [W_REM-1:0]    rem_q, rem_d;
   logic [W_MANT-1:0]   bf_q, bf_d;
   logic [Q_BITS-1:0]   quo_q, quo_d;
   logic                sign_q, sign_d;
   logic [W_EXP-1:0]    ae_q, ae_d;
   logic [W_EXP-1:0]    be_q, be_d;
   logic                busy_q, busy_d;
   logic                valid_q, valid_d;
   logic [W_FP-1:0]     quot_q, quot_d;
   logic                dz_q, dz_d;
   logic                ovf_q, ovf_d;

   logic                qbit_s;
   logic [W_REM-1:0]    rem_next_s;
   logic signed [W_ESGN-1:0] exp_s;
   logic [W_FRAC-1:0]   frac_s;
   logic                unused_lsb_s;

   assign unused_lsb_s = iA[0] ^ iB[0];

   fp27_div_step u_step (
      .rem      (rem_q),
      .divisor  (bf_q),
      .qbit     (qbit_s),
      .rem_next (rem_next_s)
   );

   // Exponent and fraction of the finished quotient, aligned on its leading one.
   always_comb begin
      exp_s = W_ESGN'(ae_q) - W_ESGN'(be_q)
            + (quo_q[Q_BITS-1] ? W_ESGN'(EXP_BIAS) : W_ESGN'(EXP_BIAS - 1));
      if (quo_q[Q_BITS-1]) begin
         frac_s = quo_q[Q_BITS-2:1];
      end else begin
         frac_s = quo_q[Q_BITS-3:0];
      end
   end

   // Next-state logic for the IDLE/DIV/NORM sequencer and its datapath.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      bf_d    = bf_q;
      quo_d   = quo_q;
      sign_d  = sign_q;
      ae_d    = ae_q;
      be_d    = be_q;
      busy_d  = busy_q;
      valid_d = 1'b0;
      quot_d  = quot_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (iStart) begin
               sign_d  = iA[SIGN_BIT] ^ iB[SIGN_BIT];
               ae_d    = iA[EXP_HI:EXP_LO];
               be_d    = iB[EXP_HI:EXP_LO];
               rem_d   = {1'b0, fp_mant(iA)};
               bf_d    = fp_mant(iB);
               quo_d   = {Q_BITS{1'b0}};
               cnt_d   = W_CNT'(Q_BITS - 1);
               busy_d  = 1'b1;
               state_d = DIV;
            end else begin
               busy_d  = 1'b0;
            end
         end
         DIV: begin
            rem_d = rem_next_s;
            quo_d = {quo_q[Q_BITS-2:0], qbit_s};
            if (cnt_q == {W_CNT{1'b0}}) begin
               state_d = NORM;
            end else begin
               cnt_d = cnt_q - {{(W_CNT-1){1'b0}}, 1'b1};
            end
         end
         NORM: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            dz_d    = 1'b0;
            ovf_d   = 1'b0;
            // Divide-by-zero outranks a zero dividend; both outrank range checks.
            if (be_q == {W_EXP{1'b0}}) begin
               quot_d = {sign_q, FP_MAX_POS[W_FP-2:0]};
               dz_d   = 1'b1;
            end else if (ae_q == {W_EXP{1'b0}}) begin
               quot_d = FP_ZERO;
            end else if (exp_s <= 10'sd0) begin
               quot_d = FP_ZERO;
            end else if (exp_s >= 10'sd255) begin
               quot_d = {sign_q, FP_MAX_POS[W_FP-2:0]};
               ovf_d  = 1'b1;
            end else begin
               quot_d = {sign_q, exp_s[W_EXP-1:0], frac_s};
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any divide in flight.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q <= IDLE;
         cnt_q   <= {W_CNT{1'b0}};
         rem_q   <= {W_REM{1'b0}};
         bf_q    <= {W_MANT{1'b0}};
         quo_q   <= {Q_BITS{1'b0}};
         sign_q  <= 1'b0;
         ae_q    <= {W_EXP{1'b0}};
         be_q    <= {W_EXP{1'b0}};
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         quot_q  <= FP_ZERO;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         bf_q    <= bf_d;
         quo_q   <= quo_d;
         sign_q  <= sign_d;
         ae_q    <= ae_d;
         be_q    <= be_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         quot_q  <= quot_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign oBusy    = busy_q;
   assign oValid   = valid_q;
   assign oQuot    = quot_q;
   assign oDivZero = dz_q;
   assign oOvf     = ovf_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter: hand-computed quotients, special cases,
// handshake behaviour and mid-operation reset.
module tb_fp_div_iter;

   logic        iClk   = 1'b0;
   logic        iRst_n = 1'b1;
   logic        iStart = 1'b0;
   logic [26:0] iA     = 27'h0;
   logic [26:0] iB     = 27'h0;
   logic        oBusy;
   logic        oValid;
   logic [26:0] oQuot;
   logic        oDivZero;
   logic        oOvf;

   int checks = 0;
   int errors = 0;

   fp_div_iter dut (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .iStart   (iStart),
      .iA       (iA),
      .iB       (iB),
      .oBusy    (oBusy),
      .oValid   (oValid),
      .oQuot    (oQuot),
      .oDivZero (oDivZero),
      .oOvf     (oOvf)
   );

   always #5 iClk = ~iClk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present operands with iStart for one edge (the accept edge), then drop it.
   task automatic launch(input string tag, input logic [26:0] a, input logic [26:0] b);
      iA     = a;
      iB     = b;
      iStart = 1'b1;
      @(posedge iClk);
      #1;
      iStart = 1'b0;
      chk({tag, "_busy"}, {31'b0, oBusy}, 32'd1);
   endtask

   // Result must arrive exactly on the 21st edge after accept; returns in the oValid cycle.
   task automatic expect_res(input string tag, input logic [26:0] q, input logic dz, input logic ov);
      for (int n = 1; n <= 21; n++) begin
         @(posedge iClk);
         #1;
         if (n < 21) begin
            chk({tag, "_early_valid"}, {31'b0, oValid}, 32'd0);
         end else begin
            chk({tag, "_valid"}, {31'b0, oValid}, 32'd1);
            chk({tag, "_busy_low"}, {31'b0, oBusy}, 32'd0);
            chk({tag, "_quot"}, {5'b0, oQuot}, {5'b0, q});
            chk({tag, "_divzero"}, {31'b0, oDivZero}, {31'b0, dz});
            chk({tag, "_ovf"}, {31'b0, oOvf}, {31'b0, ov});
         end
      end
   endtask

   task automatic quiet(input string tag, input int cycles);
      int pulses = 0;
      for (int n = 0; n < cycles; n++) begin
         @(posedge iClk);
         #1;
         if (oValid) pulses++;
      end
      chk(tag, pulses, 32'd0);
   endtask

   initial begin
      #2;
      iRst_n = 1'b0;
      #1;
      chk("rst_busy", {31'b0, oBusy}, 32'd0);
      chk("rst_valid", {31'b0, oValid}, 32'd0);
      chk("rst_quot", {5'b0, oQuot}, 32'd0);
      chk("rst_divzero", {31'b0, oDivZero}, 32'd0);
      chk("rst_ovf", {31'b0, oOvf}, 32'd0);
      @(posedge iClk);
      #1;
      iRst_n = 1'b1;
      @(posedge iClk);
      #1;

      launch("six_by_two", 27'h2060000, 27'h2000000);
      expect_res("six_by_two", 27'h2020000, 1'b0, 1'b0);
      @(posedge iClk);
      #1;
      chk("pulse_width", {31'b0, oValid}, 32'd0);
      chk("quot_held", {5'b0, oQuot}, {5'b0, 27'h2020000});

      launch("one_by_three", 27'h1FC0000, 27'h2020000);
      expect_res("one_by_three", 27'h1F55555, 1'b0, 1'b0);
      launch("neg_six_by_two", 27'h6060000, 27'h2000000);
      expect_res("neg_six_by_two", 27'h6020000, 1'b0, 1'b0);
      launch("zero_dividend", 27'h0020000, 27'h2000000);
      expect_res("zero_dividend", 27'h0000000, 1'b0, 1'b0);
      launch("div_by_zero", 27'h2020000, 27'h0000000);
      expect_res("div_by_zero", 27'h3FBFFFF, 1'b1, 1'b0);
      launch("underflow", 27'h0040000, 27'h3200000);
      expect_res("underflow", 27'h0000000, 1'b0, 1'b0);
      launch("overflow", 27'h3F80000, 27'h0040000);
      expect_res("overflow", 27'h3FBFFFF, 1'b0, 1'b1);

      // Start raised in the oValid cycle: accepted immediately, 22 cycles per divide.
      launch("back_to_back", 27'h2060000, 27'h2000000);
      expect_res("back_to_back", 27'h2020000, 1'b0, 1'b0);

      @(posedge iClk);
      #1;
      launch("busy_ignore", 27'h2060000, 27'h2000000);
      for (int n = 1; n <= 21; n++) begin
         @(posedge iClk);
         #1;
         if (n == 5 || n == 12) begin
            iA     = 27'h1FC0000;
            iB     = 27'h2020000;
            iStart = 1'b1;
         end else begin
            iStart = 1'b0;
         end
         if (n < 21) begin
            chk("busy_ignore_early_valid", {31'b0, oValid}, 32'd0);
         end else begin
            chk("busy_ignore_valid", {31'b0, oValid}, 32'd1);
            chk("busy_ignore_quot", {5'b0, oQuot}, {5'b0, 27'h2020000});
         end
      end
      quiet("busy_ignore_no_second", 30);

      launch("abort", 27'h1FC0000, 27'h2020000);
      for (int n = 0; n < 10; n++) begin
         @(posedge iClk);
      end
      #3;
      iRst_n = 1'b0;
      #1;
      chk("abort_busy", {31'b0, oBusy}, 32'd0);
      chk("abort_valid", {31'b0, oValid}, 32'd0);
      chk("abort_quot", {5'b0, oQuot}, 32'd0);
      chk("abort_divzero", {31'b0, oDivZero}, 32'd0);
      chk("abort_ovf", {31'b0, oOvf}, 32'd0);
      @(posedge iClk);
      @(posedge iClk);
      #1;
      iRst_n = 1'b1;
      quiet("abort_no_valid", 30);
      launch("after_reset", 27'h1FC0000, 27'h2020000);
      expect_res("after_reset", 27'h1F55555, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_div_iter.md
Name: fp_div_iter

Overview:
- Iterative floating-point divider for the GMM datapath's 27-bit custom float format: 1 sign, 8-bit exponent with bias 127, 18-bit fraction field.
- Inverse operation of the team's combinational FP multiplier, with identical field interpretation and zero convention; quotients feed straight back into multiplier inputs.
- Used for variance/weight normalisation, where one divide per pixel is affordable.
- Restoring division, one quotient bit per clock, fixed latency, start/valid handshake.

Parameters:
- W_EXP, 8, exponent field width
- W_FRAC, 18, fraction field width; operand mantissa = {1, field[W_FRAC-1:1]} (field LSB ignored)
- EXP_BIAS, 127, exponent bias
- Q_BITS, W_FRAC+2 (20), quotient bits produced; sets iteration count

Ports:
- iClk, in, 1, clock; all state updates on rising edge
- iRst_n, in, 1, asynchronous active-low reset
- iStart, in, 1, request; sampled only in IDLE
- iA, in, 27, dividend
- iB, in, 27, divisor
- oBusy, out, 1, high from accept until result edge
- oValid, out, 1, one-cycle pulse, result valid
- oQuot, out, 27, quotient, held until next result
- oDivZero, out, 1, divisor exponent was 0; held with oQuot
- oOvf, out, 1, exponent overflow saturated; held with oQuot

Behaviour:
- Reset, asynchronous: state=IDLE; oBusy=0, oValid=0, oQuot=27'b0, oDivZero=0, oOvf=0.
- Reset asserted mid-operation aborts with no oValid; first start after release is a normal accept.
- Field decode:
  - sign = A[26]^B[26]; Ae=A[25:18], Be=B[25:18]
  - Af={1,A[17:1]}, Bf={1,B[17:1]}
- FSM states: IDLE, DIV, NORM.
  - IDLE: iStart=1 at edge k latches operands, remainder R=Af (19 bits), counter=Q_BITS-1, sets oBusy → DIV.
  - DIV: each edge produces one quotient bit, MSB first: q[i]=(R>=Bf); R=(R-q[i]*Bf)<<1 (shift skipped after i=0). After the i=0 edge → NORM. Occupies edges k+1..k+20.
  - NORM: edge k+21 registers oQuot/flags, oValid=1 for that cycle only, oBusy=0 → IDLE.
- Fixed latency: accept at edge k → result at edge k+21, for all operands including special cases. No bypass.
- Back-to-back: iStart in the cycle oValid is high is accepted (state already IDLE). Throughput is 1 divide per 22 cycles.
- iStart while oBusy=1 is ignored; no queueing, no error.
- Quotient: q=floor(Af*2^19/Bf), range [2^18, 2^20).
  - q[19]=1 → E=Ae-Be+127, frac=q[18:1]
  - q[19]=0 → E=Ae-Be+126, frac=q[17:0]
  - Truncation only, no rounding. E computed signed, 10 bits.
- Result priority, in NORM:
  1. Be==0 → oQuot={sign,8'hFE,18'h3FFFF}, oDivZero=1
  2. Ae==0 → oQuot=27'b0
  3. E<=0 → oQuot=27'b0 (underflow)
  4. E>=255 → oQuot={sign,8'hFE,18'h3FFFF}, oOvf=1
  5. otherwise → {sign,E[7:0],frac}
- Flags not set by the current result are cleared at the same edge.
- Zero output is all-zero (no signed zero), matching the multiplier.

Decomposition:
- Package fp27_pkg:
  - W_EXP, W_FRAC, EXP_BIAS constants
  - FP_ZERO, FP_MAX_POS constants
  - field-select localparams for sign/exp/frac
  - FSM state enum {IDLE, DIV, NORM}
- Sub-module fp27_div_step: combinational single restoring step; (R, Bf) → (qbit, Rnext). Instantiated once and iterated by the FSM.

Test Plan:
- 6.0/2.0: iA=27'h2060000, iB=27'h2000000 → oQuot=27'h2020000 at exactly the 21st edge after accept; oValid one cycle; flags 0.
- 1.0/3.0: iA=27'h1FC0000, iB=27'h2020000 → oQuot=27'h1F55555 (truncated).
- Sign and zero: -6.0/2.0 (27'h6060000, 27'h2000000) → 27'h6020000; Ae=0 dividend → 27'h0000000.
- Special cases: 3.0/0 (iB exp=0) → 27'h3FBFFFF, oDivZero=1. Exp 1 / exp 200 → 27'h0. Exp 254 / exp 1 → 27'h3FBFFFF, oOvf=1.
- Handshake: iStart pulsed at cycles 5 and 12 of a busy op → only the first result appears. iStart in the oValid cycle → second result 22 cycles after the first.
- Reset: assert iRst_n=0 at iteration 10 → all outputs 0 asynchronously, no oValid. Next op after release completes normally.
